// File: rtl/frame_scheduler.sv
// rtl/frame_scheduler.sv - per-frame rasterizer sequencer over a double-buffered frame store
//
// Purpose: starts the rasterizer once per frame, waits for done, swaps the
// write/read buffer selects on the next vsync rising edge, flags vsyncs that
// arrive while a render is still in flight and aborts hung renders with a
// watchdog.
//
// Optional feature macro: FRAME_SCHED_STATS_EN (saturating overrun counter).
//
// Ports:
//   i_clk            system clock, rising edge
//   i_arst_n         asynchronous active-low reset
//   i_enable         level, 1 = render continuously
//   i_vsync          vsync level, synchronous to i_clk
//   i_raster_done    rasterizer done level
//   o_raster_go      1-cycle start pulse to rasterizer
//   o_write_buf_sel  buffer the rasterizer writes
//   o_read_buf_sel   buffer the display reads (~o_write_buf_sel)
//   o_frame_count    completed (swapped) frames, wraps
//   o_overrun        1-cycle pulse, vsync edge seen during GO/ARM/RENDER
//   o_timeout        1-cycle pulse, watchdog abort
//   o_busy           1 in any state except IDLE
//   o_drop_count     overrun counter (0 unless FRAME_SCHED_STATS_EN)

module frame_scheduler #(
  parameter int TIMEOUT_CYCLES = 19200,
  parameter int FRAME_CNT_W    = 16,
  parameter int DROP_CNT_W     = 8
) (
  input  logic                   i_clk,
  input  logic                   i_arst_n,
  input  logic                   i_enable,
  input  logic                   i_vsync,
  input  logic                   i_raster_done,
  output logic                   o_raster_go,
  output logic                   o_write_buf_sel,
  output logic                   o_read_buf_sel,
  output logic [FRAME_CNT_W-1:0] o_frame_count,
  output logic                   o_overrun,
  output logic                   o_timeout,
  output logic                   o_busy,
  output logic [DROP_CNT_W-1:0]  o_drop_count
);

  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GO,
    ST_ARM,
    ST_RENDER,
    ST_WAIT_VS
  } state_t;

  state_t                 state_q;
  logic                   vsync_q;
  logic                   go_q;
  logic                   timeout_q;
  logic                   overrun_q;
  logic                   wsel_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;
  logic [WD_W-1:0]        wd_q;
  logic [WD_W-1:0]        wd_d;
  logic                   vs_rise;
  logic                   in_frame;

  assign vs_rise     = i_vsync & ~vsync_q;
  // A render is in flight from the go pulse until done is accepted.
  assign in_frame    = (state_q == ST_GO) || (state_q == ST_ARM) || (state_q == ST_RENDER);
  assign frame_cnt_d = frame_cnt_q + 1'b1;
  assign wd_d        = wd_q + 1'b1;

  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      state_q     <= ST_IDLE;
      vsync_q     <= 1'b0;
      go_q        <= 1'b0;
      timeout_q   <= 1'b0;
      overrun_q   <= 1'b0;
      wsel_q      <= 1'b0;
      frame_cnt_q <= '0;
      wd_q        <= '0;
    end else begin
      vsync_q   <= i_vsync;
      go_q      <= 1'b0;
      timeout_q <= 1'b0;
      // Display keeps the old buffer; only report the missed edge.
      overrun_q <= vs_rise & in_frame;

      case (state_q)
        ST_IDLE: begin
          if (i_enable) begin
            state_q <= ST_GO;
            go_q    <= 1'b1;
          end
        end
        ST_GO: begin
          state_q <= ST_ARM;
        end
        ST_ARM: begin
          // Done may still be high from the previous frame; ignore it here.
          state_q <= ST_RENDER;
          wd_q    <= '0;
        end
        ST_RENDER: begin
          wd_q <= wd_d;
          if (i_raster_done) begin
            state_q <= ST_WAIT_VS;
          end else if (wd_q == WD_LAST) begin
            // Retry into the same buffer; selects stay put.
            state_q   <= ST_GO;
            go_q      <= 1'b1;
            timeout_q <= 1'b1;
          end
        end
        ST_WAIT_VS: begin
          if (vs_rise) begin
            wsel_q      <= ~wsel_q;
            frame_cnt_q <= frame_cnt_d;
            if (i_enable) begin
              state_q <= ST_GO;
              go_q    <= 1'b1;
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_raster_go     = go_q;
  assign o_write_buf_sel = wsel_q;
  assign o_read_buf_sel  = ~wsel_q;
  assign o_frame_count   = frame_cnt_q;
  assign o_overrun       = overrun_q;
  assign o_timeout       = timeout_q;
  assign o_busy          = (state_q != ST_IDLE);

`ifdef FRAME_SCHED_STATS_EN
  logic [DROP_CNT_W-1:0] drop_cnt_q;

  // Counts on the same edge that raises o_overrun; saturates at all-ones.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      drop_cnt_q <= '0;
    end else if (vs_rise && in_frame && (drop_cnt_q != {DROP_CNT_W{1'b1}})) begin
      drop_cnt_q <= drop_cnt_q + 1'b1;
    end
  end

  assign o_drop_count = drop_cnt_q;
`else
  assign o_drop_count = '0;
`endif

endmodule

// File: tb/tb_frame_scheduler.sv
// tb/tb_frame_scheduler.sv - randomized self-checking bench for frame_scheduler
module tb_frame_scheduler;

  localparam int TO = 100;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic        vs;
  logic        done;
  logic        go;
  logic        wsel;
  logic        rsel;
  logic [15:0] fcnt;
  logic        ovr;
  logic        tmo;
  logic        busy;
  logic [7:0]  drop;

  frame_scheduler #(
    .TIMEOUT_CYCLES(TO),
    .FRAME_CNT_W   (16),
    .DROP_CNT_W    (8)
  ) dut (
    .i_clk          (clk),
    .i_arst_n       (rst_n),
    .i_enable       (en),
    .i_vsync        (vs),
    .i_raster_done  (done),
    .o_raster_go    (go),
    .o_write_buf_sel(wsel),
    .o_read_buf_sel (rsel),
    .o_frame_count  (fcnt),
    .o_overrun      (ovr),
    .o_timeout      (tmo),
    .o_busy         (busy),
    .o_drop_count   (drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    else n_pass++;
  endtask

  // Reference model: frame phase 0 idle, 1 go issued, 2 arming, 3 rendering,
  // 4 waiting for vsync. Expected outputs follow the scheduling rules.
  int m_phase, m_wd, m_fcnt, m_drop;
  bit m_wsel, m_go, m_ovr, m_to, m_vprev;

  function automatic void model_reset();
    m_phase = 0; m_wd = 0; m_fcnt = 0; m_drop = 0;
    m_wsel = 0; m_go = 0; m_ovr = 0; m_to = 0; m_vprev = 0;
  endfunction

  function automatic void model_step(input bit e, input bit v, input bit d);
    bit rise;
    rise    = v && !m_vprev;
    m_vprev = v;
    m_ovr   = rise && (m_phase >= 1 && m_phase <= 3);
    if (m_ovr && m_drop < 255) m_drop++;
    m_go = 0;
    m_to = 0;
    if (m_phase == 0) begin
      if (e) begin m_phase = 1; m_go = 1; end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else if (m_phase == 2) begin
      m_phase = 3; m_wd = 0;
    end else if (m_phase == 3) begin
      if (d) m_phase = 4;
      else if (m_wd == TO - 1) begin m_phase = 1; m_go = 1; m_to = 1; end
      else m_wd++;
    end else begin
      if (rise) begin
        m_wsel = !m_wsel;
        m_fcnt = (m_fcnt + 1) % 65536;
        m_phase = e ? 1 : 0;
        m_go = e;
      end
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".go"},   32'(go),   32'(m_go));
    check({tag, ".wsel"}, 32'(wsel), 32'(m_wsel));
    check({tag, ".rsel"}, 32'(rsel), 32'(!m_wsel));
    check({tag, ".fcnt"}, 32'(fcnt), 32'(m_fcnt));
    check({tag, ".ovr"},  32'(ovr),  32'(m_ovr));
    check({tag, ".tmo"},  32'(tmo),  32'(m_to));
    check({tag, ".busy"}, 32'(busy), 32'(m_phase != 0));
`ifdef FRAME_SCHED_STATS_EN
    check({tag, ".drop"}, 32'(drop), 32'(m_drop));
`else
    check({tag, ".drop"}, 32'(drop), 32'd0);
`endif
  endtask

  // Rasterizer and display-timing stand-ins.
  int lat, hold, vcnt;
  bit hang;

  task automatic env_reset();
    lat = 0; hold = 0; hang = 0; vcnt = 60;
    done = 0; vs = 0;
  endtask

  task automatic drive_inputs(input int en_flip_1_in);
    if (m_go) begin
      hold = ($urandom % 4 == 0) ? 2 : 0;
      hang = ($urandom % 8 == 0);
      lat  = $urandom_range(1, 40);
      if (hold == 0) done = 0;
    end else if (hold > 0) begin
      hold--;
      if (hold == 0) done = 0;
    end else if (!done && !hang) begin
      if (lat == 0) done = 1;
      else lat--;
    end
    if (vcnt == 0) vcnt = $urandom_range(20, 150);
    else vcnt--;
    vs = (vcnt < 3);
    if (en_flip_1_in > 0 && ($urandom % en_flip_1_in == 0)) en = !en;
  endtask

  task automatic run_cycles(input int n, input int flip, input string tag);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_all(tag);
      drive_inputs(flip);
      model_step(en, vs, done);
    end
  endtask

  initial begin
    rst_n = 0;
    en    = 0;
    env_reset();
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    rst_n = 1;
    en    = 1;
    model_step(en, vs, done);

    run_cycles(1500, 300, "rand");

    // Asynchronous reset mid-operation, asserted away from any clock edge.
    @(negedge clk);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    env_reset();
    check_all("rst_mid");
    @(negedge clk);
    check_all("rst_hold");
    rst_n = 1;
    en    = 1;
    model_step(en, vs, done);

    run_cycles(1500, 300, "rand2");

    // Drain to idle with enable low; no further go may appear.
    en = 0;
    begin
      int guard = 0;
      while (m_phase != 0 && guard < 2000) begin
        run_cycles(1, 0, "drain");
        guard++;
      end
      check("drain_idle", 32'(m_phase == 0), 32'd1);
    end
    run_cycles(50, 0, "idle");

    // Frame counter wrap from 16'hFFFF.
    @(negedge clk);
    check_all("pre_force");
    force dut.frame_cnt_q = 16'hFFFF;
    #1;
    release dut.frame_cnt_q;
    m_fcnt = 16'hFFFF;
    check("forced", 32'(fcnt), 32'hFFFF);
    en = 1;
    drive_inputs(0);
    model_step(en, vs, done);
    run_cycles(600, 0, "wrap");
    check("wrapped", 32'(m_fcnt < 16'hFFFF), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
